// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle multiply unit: operation codes and FSM states.
package mc_pkg;
  localparam logic [1:0] MUL_OP   = 2'b00;
  localparam logic [1:0] MLA_OP   = 2'b01;
  localparam logic [1:0] UMULL_OP = 2'b10;
  localparam logic [1:0] SMULL_OP = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
endpackage

// File: rtl/mc_mul_if.sv
// Request/response bundle between the control FSM (master) and the multiply unit (slave).
interface mc_mul_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] acc;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;
  logic             flag_n;
  logic             flag_z;

  modport master (output start, op, a, b, acc,
                  input  busy, done, result_lo, result_hi, flag_n, flag_z);
  modport slave  (input  start, op, a, b, acc,
                  output busy, done, result_lo, result_hi, flag_n, flag_z);
endinterface

// File: rtl/flopenr.sv
// Enabled register with synchronous active-high reset.
module flopenr #(parameter int WIDTH = 8) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk) begin
    if (reset)   q <= '0;
    else if (en) q <= d;
  end
endmodule

// File: rtl/mc_mul_core.sv
// Radix-2 unsigned shift-add engine: one multiplier bit per step, WIDTH+1-bit adder.
module mc_mul_core #(parameter int WIDTH = 32) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   mcand_in,
  input  logic [WIDTH-1:0]   mplier_in,
  output logic [2*WIDTH-1:0] product
);
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH:0]   sum;

  // The carry out of the upper half becomes the top bit after the right shift.
  assign sum = {1'b0, product[2*WIDTH-1:WIDTH]}
             + ({(WIDTH+1){mplier[0]}} & {1'b0, mcand});

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand   <= '0;
      mplier  <= '0;
      product <= '0;
    end else if (load) begin
      mcand   <= mcand_in;
      mplier  <= mplier_in;
      product <= '0;
    end else if (step) begin
      product <= {sum, product[WIDTH-1:1]};
      mplier  <= mplier >> 1;
    end
  end
endmodule

// File: rtl/mc_mul_unit.sv
// Iterative MUL/MLA/UMULL/SMULL unit: FSM, operand latches, sign fix, accumulate and flags.
module mc_mul_unit
  import mc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     reset,
  mc_mul_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  state_t             state, next_state;
  logic [CW-1:0]      count;
  logic               load;
  logic               is_smull;
  logic [1:0]         op_l;
  logic [WIDTH-1:0]   acc_l;
  logic               sign_l;
  logic [2*WIDTH-1:0] product;
  logic [2*WIDTH-1:0] fixed;
  logic               long_op;
  logic               n_next;
  logic               z_next;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic signed_op);
    return (signed_op && v[WIDTH-1]) ? (~v + 1'b1) : v;
  endfunction

  assign load     = bus.start && (state == IDLE || state == DONE);
  assign is_smull = (bus.op == SMULL_OP);
  assign long_op  = op_l[1];

  flopenr #(.WIDTH(2))     op_reg   (.clk(clk), .reset(reset), .en(load), .d(bus.op),  .q(op_l));
  flopenr #(.WIDTH(WIDTH)) acc_reg  (.clk(clk), .reset(reset), .en(load), .d(bus.acc), .q(acc_l));
  flopenr #(.WIDTH(1))     sign_reg (.clk(clk), .reset(reset), .en(load),
                                     .d(is_smull & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1])), .q(sign_l));

  mc_mul_core #(.WIDTH(WIDTH)) core (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .step     (state == RUN),
    .mcand_in (magnitude(bus.a, is_smull)),
    .mplier_in(magnitude(bus.b, is_smull)),
    .product  (product)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= next_state;
      if (load)                         count <= CW'(WIDTH - 1);
      else if (state == RUN && count != '0) count <= count - 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.start) next_state = RUN;
      RUN:     if (count == '0) next_state = FIX;
      FIX:     next_state = DONE;
      DONE:    next_state = bus.start ? RUN : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // FIX stage: restore sign, accumulate, truncate short ops, derive flags.
  always_comb begin
    fixed  = product;
    n_next = 1'b0;
    z_next = 1'b0;
    if (op_l == SMULL_OP && sign_l) fixed = ~product + 1'b1;
    if (op_l == MLA_OP) fixed[WIDTH-1:0] = product[WIDTH-1:0] + acc_l;
    if (!long_op) fixed[2*WIDTH-1:WIDTH] = '0;
    if (long_op) begin
      n_next = fixed[2*WIDTH-1];
      z_next = (fixed == '0);
    end else begin
      n_next = fixed[WIDTH-1];
      z_next = (fixed[WIDTH-1:0] == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.result_lo <= '0;
      bus.result_hi <= '0;
      bus.flag_n    <= 1'b0;
      bus.flag_z    <= 1'b0;
    end else if (state == FIX) begin
      bus.result_lo <= fixed[WIDTH-1:0];
      bus.result_hi <= fixed[2*WIDTH-1:WIDTH];
      bus.flag_n    <= n_next;
      bus.flag_z    <= z_next;
    end
  end

  assign bus.busy = (state == RUN) || (state == FIX);
  assign bus.done = (state == DONE);
endmodule

// File: tb/tb_mc_mul_unit.sv
// Table-driven scoreboard bench for mc_mul_unit, plus handshake corner-case sequences.
module tb_mc_mul_unit;
  localparam int W = 32;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, acc;
    logic [31:0] hi, lo;
    logic        n, z;
  } vec_t;

  typedef struct {
    logic [31:0] hi, lo;
    logic        n, z;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  int   hold_viol = 0;
  logic [65:0] snap = '0;
  exp_t q[$];
  vec_t tab[$];

  mc_mul_if #(.WIDTH(W)) bus ();
  mc_mul_unit #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] op, input logic [31:0] a, b, acc,
                              input logic [31:0] hi, lo, input logic n, z);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.acc = acc; v.hi = hi; v.lo = lo; v.n = n; v.z = z;
    return v;
  endfunction

  function automatic vec_t model(input logic [1:0] op, input logic [31:0] a, b, acc);
    logic [63:0] p;
    case (op)
      2'b00:   p = {32'h0, a * b};
      2'b01:   p = {32'h0, a * b + acc};
      2'b10:   p = {32'h0, a} * {32'h0, b};
      default: p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    endcase
    return mk(op, a, b, acc, p[63:32], p[31:0],
              op[1] ? p[63] : p[31],
              op[1] ? (p == 64'h0) : (p[31:0] == 32'h0));
  endfunction

  // Response side: pop one expectation per done pulse.
  always @(negedge clk) begin
    if (bus.done) begin
      done_cnt++;
      if (q.size() == 0) begin
        chk("unexpected_done", 64'(done_cnt), 64'(0));
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("result_hi", 64'(bus.result_hi), 64'(e.hi));
        chk("result_lo", 64'(bus.result_lo), 64'(e.lo));
        chk("flag_n", 64'(bus.flag_n), 64'(e.n));
        chk("flag_z", 64'(bus.flag_z), 64'(e.z));
        chk("latency", 64'(cyc), 64'(e.cyc + W + 2));
      end
    end
    if (bus.busy) begin
      if ({bus.result_hi, bus.result_lo, bus.flag_n, bus.flag_z} !== snap) hold_viol++;
    end else begin
      snap = {bus.result_hi, bus.result_lo, bus.flag_n, bus.flag_z};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    bus.op = v.op; bus.a = v.a; bus.b = v.b; bus.acc = v.acc;
  endtask

  task automatic push(input vec_t v);
    exp_t e;
    e.hi = v.hi; e.lo = v.lo; e.n = v.n; e.z = v.z; e.cyc = cyc;
    q.push_back(e);
  endtask

  task automatic issue(input vec_t v);
    drive(v);
    bus.start = 1'b1;
    push(v);
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((q.size() != 0 || bus.busy) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) begin
      chk("drain_timeout", 64'(q.size()), 64'(0));
      q.delete();
    end
  endtask

  initial begin
    vec_t v1, v2;
    int   d0;
    int   n;

    tab.push_back(mk(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFE, 32'h00000001, 1, 0));
    tab.push_back(mk(2'b11, 32'hFFFFFFFD, 32'h00000005, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFF1, 1, 0));
    tab.push_back(mk(2'b11, 32'h80000000, 32'h80000000, 32'h0, 32'h40000000, 32'h00000000, 0, 0));
    tab.push_back(mk(2'b01, 32'h00000007, 32'h00000006, 32'd100, 32'h0, 32'h0000008E, 0, 0));
    tab.push_back(mk(2'b00, 32'h00010000, 32'h00010000, 32'h0, 32'h0, 32'h00000000, 0, 1));
    tab.push_back(mk(2'b10, 32'h00000000, 32'h12345678, 32'h0, 32'h0, 32'h00000000, 0, 1));
    tab.push_back(mk(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h00000000, 32'h00000001, 0, 0));
    tab.push_back(mk(2'b00, 32'hFFFFFFFF, 32'h00000002, 32'h5, 32'h0, 32'hFFFFFFFE, 1, 0));
    tab.push_back(mk(2'b01, 32'hFFFFFFFF, 32'h00000001, 32'h1, 32'h0, 32'h00000000, 0, 1));
    tab.push_back(mk(2'b11, 32'h00000007, 32'hFFFFFFFE, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFF2, 1, 0));
    tab.push_back(mk(2'b11, 32'h80000000, 32'h00000001, 32'h0, 32'hFFFFFFFF, 32'h80000000, 1, 0));
    tab.push_back(mk(2'b11, 32'h80000000, 32'h7FFFFFFF, 32'h0, 32'hC0000000, 32'h80000000, 1, 0));
    for (int i = 0; i < 8; i++)
      tab.push_back(model(2'(i % 4), $urandom, $urandom, $urandom));

    reset = 1'b1;
    bus.start = 1'b0;
    drive(tab[0]);
    tick();
    tick();
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_done", 64'(bus.done), 64'(0));
    chk("rst_lo", 64'(bus.result_lo), 64'(0));
    chk("rst_hi", 64'(bus.result_hi), 64'(0));
    chk("rst_n", 64'(bus.flag_n), 64'(0));
    chk("rst_z", 64'(bus.flag_z), 64'(0));
    reset = 1'b0;
    tick();

    foreach (tab[i]) begin
      issue(tab[i]);
      chk("busy_in_run", 64'(bus.busy), 64'(1));
      wait_drain(100);
    end

    // start during RUN is ignored; one done with the original result
    d0 = done_cnt;
    issue(tab[0]);
    repeat (4) tick();
    drive(tab[3]);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_drain(100);
    repeat (40) tick();
    chk("single_done", 64'(done_cnt), 64'(d0 + 1));

    // reset in the middle of RUN
    d0 = done_cnt;
    issue(tab[1]);
    repeat (8) tick();
    reset = 1'b1;
    tick();
    chk("mid_rst_busy", 64'(bus.busy), 64'(0));
    chk("mid_rst_done", 64'(bus.done), 64'(0));
    chk("mid_rst_lo", 64'(bus.result_lo), 64'(0));
    chk("mid_rst_hi", 64'(bus.result_hi), 64'(0));
    chk("mid_rst_n", 64'(bus.flag_n), 64'(0));
    chk("mid_rst_z", 64'(bus.flag_z), 64'(0));
    reset = 1'b0;
    q.delete();
    repeat (45) tick();
    chk("no_done_after_rst", 64'(done_cnt), 64'(d0));
    issue(tab[2]);
    wait_drain(100);

    // start held high through the DONE cycle: back-to-back acceptance
    v1 = tab[3];
    v2 = tab[11];
    drive(v1);
    bus.start = 1'b1;
    push(v1);
    tick();
    drive(v2);
    n = 0;
    while (!bus.done && n < 60) begin
      tick();
      n++;
    end
    chk("b2b_done_seen", 64'(bus.done), 64'(1));
    chk("b2b_busy_in_done", 64'(bus.busy), 64'(0));
    push(v2);
    tick();
    bus.start = 1'b0;
    chk("b2b_no_gap", 64'(bus.busy), 64'(1));
    wait_drain(100);

    chk("outputs_held_while_busy", 64'(hold_viol), 64'(0));
    chk("scoreboard_empty", 64'(q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
